ddr3_vpi_wr_arbiter: RTL and testbench
======================================

DDR3_VPI_WR_ARBITER -- requirements
Module: ddr3_vpi_wr_arbiter

Interface
REQ-001 Parameters SHALL be: CHN_BITS, default 2, channel index width (CHN_NUM = 2**CHN_BITS); FRM_BITS, default 2, frame-buffer index width; ADDR_WIDTH, default 27, DDR word address width; LEN_WIDTH, default 12, burst length width; TIMEOUT_CYC, default 4095, service watchdog limit.
REQ-002 OFS_WIDTH SHALL equal ADDR_WIDTH-CHN_BITS-FRM_BITS.
REQ-003 i_ddr_clk, input, 1: the only clock; all logic is on its rising edge.
REQ-004 i_rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 i_soft_rst, input, 1: synchronous clear, active-high.
REQ-006 i_chn_req, input, CHN_NUM: per-channel one-cycle pulse meaning "one burst is ready".
REQ-007 i_chn_vs, input, CHN_NUM: per-channel one-cycle frame-start pulse, already in the i_ddr_clk domain.
REQ-008 i_chn_len, input, CHN_NUM*LEN_WIDTH: per-channel burst length; channel k occupies bits [k*LEN_WIDTH +: LEN_WIDTH].
REQ-009 i_arb_mode, input, 1: 0 selects round-robin arbitration; 1 selects fixed priority, lowest index first.
REQ-010 i_ddr_ack, input, 1: DDR controller accepts the request.
REQ-011 i_ddr_wr_done, input, 1: the granted burst is fully written.
REQ-012 o_ddr_req, output, 1: write request to the DDR controller.
REQ-013 o_ddr_start_addr, output, ADDR_WIDTH: burst address laid out as {channel, frame, offset}.
REQ-014 o_ddr_data_length, output, LEN_WIDTH: burst length.
REQ-015 o_chn_grant, output, CHN_NUM: one-hot grant to the channel currently in service.
REQ-016 o_chn_frame, output, CHN_NUM*FRM_BITS: current frame index of each channel.
REQ-017 o_req_lose, output, CHN_NUM: one-cycle pulse marking a dropped request.
REQ-018 o_timeout, output, 1: one-cycle pulse marking a watchdog abort.

Function
REQ-019 The block SHALL keep, per channel, a pending bit, a frame counter (FRM_BITS), an offset (OFS_WIDTH) and a deferred-vs bit.
REQ-020 i_chn_req[k] SHALL set pending[k] on the next edge; if pending[k] is already 1, the block SHALL instead pulse o_req_lose[k] for one cycle, leaving pending[k] at 1.
REQ-021 The FSM SHALL have states IDLE, ARB, REQ and WAIT_DONE.
REQ-022 IDLE SHALL move to ARB when any pending bit is set.
REQ-023 In ARB, the block SHALL select a winner: round-robin searches upward from last_grant+1 with wrap-around; fixed priority takes the lowest pending index.
REQ-024 On leaving ARB, the block SHALL register o_chn_grant, o_ddr_start_addr = {k, frame[k], offset[k]} and o_ddr_data_length = len[k]; clear pending[k]; update last_grant; move to REQ.
REQ-025 Latency SHALL be: req pulse sampled at edge 0 from IDLE -> o_ddr_req high after edge 3.
REQ-026 In REQ, o_ddr_req SHALL stay high until i_ddr_ack is sampled; it then drops on the next edge and the FSM moves to WAIT_DONE.
REQ-027 i_ddr_wr_done SHALL be ignored outside WAIT_DONE.
REQ-028 In WAIT_DONE, i_ddr_wr_done SHALL apply offset[k] += length modulo 2**OFS_WIDTH (wrap, no flag), clear o_chn_grant and return to IDLE.
REQ-029 A new i_chn_req[k] while channel k is in service SHALL set pending[k] without a lose pulse, because pending was cleared at grant.
REQ-030 i_chn_vs[k] while k is not in service SHALL set frame[k] to frame[k]+1 modulo 2**FRM_BITS and offset[k] to 0 on the next edge; pending[k] SHALL be unaffected.
REQ-031 i_chn_vs[k] while k is in service (REQ or WAIT_DONE) SHALL set deferred-vs[k].
REQ-032 At wr_done or timeout with deferred-vs[k] set, the block SHALL apply the frame increment and offset clear instead of the offset advance, then clear deferred-vs[k].
REQ-033 A watchdog SHALL count cycles spent in REQ plus WAIT_DONE.
REQ-034 When the watchdog reaches TIMEOUT_CYC, the block SHALL pulse o_timeout, drop o_ddr_req and o_chn_grant, leave the offset unchanged (the burst is lost) and return to IDLE.
REQ-035 The watchdog SHALL clear on entry to IDLE.
REQ-036 A length of 0 SHALL be legal; the offset is unchanged at wr_done.
REQ-037 Arbitration SHALL always be performed by logic equivalent to full 2**CHN_BITS bit vectors.

Reset
REQ-038 Asserting i_rst_n low SHALL immediately drive all outputs to 0, the FSM to IDLE, all counters, offsets and pending/deferred bits to 0, and last_grant to CHN_NUM-1, so channel 0 wins first.
REQ-039 i_soft_rst SHALL produce the same state on the next edge, taking precedence over all other inputs, including mid-transfer.

Verification
REQ-040 Round-robin, all four channels pulse req at once, ack and wr_done one cycle after each request -> grants in order 0,1,2,3; o_ddr_req first high 3 clocks after the pulse.
REQ-041 Fixed mode, channel 2 with len=256 repeating and channel 0 pulsing once -> channel 0 is served next; channel 2 addresses step 0x000, 0x100, 0x200 in the offset field.
REQ-042 Two req pulses on channel 1 with no service between them -> exactly one o_req_lose[1] pulse; one burst issued.
REQ-043 vs[3] during WAIT_DONE of channel 3 -> after wr_done, frame[3] = 1 and offset = 0; next address = {3,1,0}.
REQ-044 TIMEOUT_CYC=16, no ack -> o_timeout pulses 16 cycles after REQ entry; offset unchanged; the next pending channel is granted.
REQ-045 Offset at 2**OFS_WIDTH-16, len=32 -> offset wraps to 16; soft reset during REQ -> o_ddr_req=0 the next cycle and all offsets 0.

Source files
------------

// File: rtl/ddr3_vpi_wr_arbiter.sv
// Write-side arbiter: per-channel burst requests share one DDR write master; addresses are {channel, frame, offset}.
// One burst in flight at a time; o_ddr_req holds until i_ddr_ack; a watchdog aborts stalled bursts.
module ddr3_vpi_wr_arbiter #(
    parameter int CHN_BITS    = 2,
    parameter int FRM_BITS    = 2,
    parameter int ADDR_WIDTH  = 27,
    parameter int LEN_WIDTH   = 12,
    parameter int TIMEOUT_CYC = 4095
) (
    input  logic                               i_ddr_clk,
    input  logic                               i_rst_n,
    input  logic                               i_soft_rst,
    input  logic [(2**CHN_BITS)-1:0]           i_chn_req,
    input  logic [(2**CHN_BITS)-1:0]           i_chn_vs,
    input  logic [(2**CHN_BITS)*LEN_WIDTH-1:0] i_chn_len,
    input  logic                               i_arb_mode,
    input  logic                               i_ddr_ack,
    input  logic                               i_ddr_wr_done,
    output logic                               o_ddr_req,
    output logic [ADDR_WIDTH-1:0]              o_ddr_start_addr,
    output logic [LEN_WIDTH-1:0]               o_ddr_data_length,
    output logic [(2**CHN_BITS)-1:0]           o_chn_grant,
    output logic [(2**CHN_BITS)*FRM_BITS-1:0]  o_chn_frame,
    output logic [(2**CHN_BITS)-1:0]           o_req_lose,
    output logic                               o_timeout
);
    localparam int CHN_NUM   = 2**CHN_BITS;
    localparam int OFS_WIDTH = ADDR_WIDTH - CHN_BITS - FRM_BITS;
    localparam int WD_W      = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_ARB, S_REQ, S_WAIT} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CHN_NUM-1:0]    r_pend;
    logic [CHN_NUM-1:0]    r_defer;
    logic [FRM_BITS-1:0]   r_frame [CHN_NUM];
    logic [OFS_WIDTH-1:0]  r_ofs   [CHN_NUM];
    logic [CHN_BITS-1:0]   r_last;
    logic [WD_W-1:0]       r_wdog;
    logic                  r_ddr_req;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [CHN_NUM-1:0]    r_grant;
    logic [CHN_NUM-1:0]    r_lose;
    logic                  r_tmo;

    logic [LEN_WIDTH-1:0]  w_len [CHN_NUM];
    logic [CHN_BITS-1:0]   w_win;
    logic [CHN_BITS-1:0]   w_idx;
    logic                  w_found;
    logic                  w_in_srv;
    logic                  w_grant;
    logic                  w_ack;
    logic                  w_done;
    logic                  w_tmo;
    logic                  w_finish;

    always_comb begin
        o_chn_frame = '0;
        for (int k = 0; k < CHN_NUM; k++) begin
            w_len[k] = i_chn_len[k*LEN_WIDTH +: LEN_WIDTH];
            o_chn_frame[k*FRM_BITS +: FRM_BITS] = r_frame[k];
        end
    end

    // Loops run from farthest to nearest candidate so the nearest pending one is written last and wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        if (i_arb_mode) begin
            for (int i = CHN_NUM - 1; i >= 0; i--) begin
                if (r_pend[i]) begin
                    w_found = 1'b1;
                    w_win   = CHN_BITS'(i);
                end
            end
        end else begin
            for (int i = CHN_NUM; i >= 1; i--) begin
                w_idx = r_last + CHN_BITS'(i);
                if (r_pend[w_idx]) begin
                    w_found = 1'b1;
                    w_win   = w_idx;
                end
            end
        end
    end

    assign w_in_srv = (r_state == S_REQ) || (r_state == S_WAIT);
    assign w_grant  = (r_state == S_ARB) && w_found;
    assign w_ack    = (r_state == S_REQ) && r_ddr_req && i_ddr_ack;
    assign w_done   = (r_state == S_WAIT) && i_ddr_wr_done;
    assign w_tmo    = w_in_srv && !w_done && (r_wdog == WD_W'(TIMEOUT_CYC - 1));
    assign w_finish = w_done || w_tmo;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (|r_pend) w_state_nxt = S_ARB;
            S_ARB:  w_state_nxt = w_found ? S_REQ : S_IDLE;
            S_REQ: begin
                if (w_tmo)      w_state_nxt = S_IDLE;
                else if (w_ack) w_state_nxt = S_WAIT;
            end
            S_WAIT: if (w_finish) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_ddr_clk or negedge i_rst_n) begin
        if (!i_rst_n)        r_state <= S_IDLE;
        else if (i_soft_rst) r_state <= S_IDLE;
        else                 r_state <= w_state_nxt;
    end

    always_ff @(posedge i_ddr_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pend <= '0; r_defer <= '0; r_last <= CHN_BITS'(CHN_NUM - 1); r_wdog <= '0;
            r_ddr_req <= 1'b0; r_addr <= '0; r_len <= '0; r_grant <= '0; r_lose <= '0; r_tmo <= 1'b0;
            for (int k = 0; k < CHN_NUM; k++) begin
                r_frame[k] <= '0;
                r_ofs[k]   <= '0;
            end
        end else if (i_soft_rst) begin
            r_pend <= '0; r_defer <= '0; r_last <= CHN_BITS'(CHN_NUM - 1); r_wdog <= '0;
            r_ddr_req <= 1'b0; r_addr <= '0; r_len <= '0; r_grant <= '0; r_lose <= '0; r_tmo <= 1'b0;
            for (int k = 0; k < CHN_NUM; k++) begin
                r_frame[k] <= '0;
                r_ofs[k]   <= '0;
            end
        end else begin
            r_lose    <= '0;
            r_tmo     <= w_tmo;
            r_wdog    <= w_in_srv ? r_wdog + WD_W'(1) : '0;
            r_ddr_req <= (r_state == S_REQ) && !w_ack && !w_tmo;
            for (int k = 0; k < CHN_NUM; k++) begin
                // A request landing on the grant edge re-arms pending instead of being reported lost.
                if (i_chn_req[k]) begin
                    r_pend[k] <= 1'b1;
                    if (r_pend[k] && !(w_grant && (w_win == CHN_BITS'(k))))
                        r_lose[k] <= 1'b1;
                end else if (w_grant && (w_win == CHN_BITS'(k))) begin
                    r_pend[k] <= 1'b0;
                end
                if (i_chn_vs[k]) begin
                    if (r_grant[k]) begin
                        r_defer[k] <= 1'b1;
                    end else begin
                        r_frame[k] <= r_frame[k] + FRM_BITS'(1);
                        r_ofs[k]   <= '0;
                    end
                end
            end
            if (w_grant) begin
                r_grant <= CHN_NUM'(1) << w_win;
                r_addr  <= {w_win, r_frame[w_win], r_ofs[w_win]};
                r_len   <= w_len[w_win];
                r_last  <= w_win;
            end
            if (w_finish) begin
                r_grant <= '0;
                r_wdog  <= '0;
                if (r_defer[r_last] || i_chn_vs[r_last]) begin
                    r_frame[r_last] <= r_frame[r_last] + FRM_BITS'(1);
                    r_ofs[r_last]   <= '0;
                    r_defer[r_last] <= 1'b0;
                end else if (w_done) begin
                    r_ofs[r_last] <= r_ofs[r_last] + OFS_WIDTH'(r_len);
                end
            end
        end
    end

    assign o_ddr_req         = r_ddr_req;
    assign o_ddr_start_addr  = r_addr;
    assign o_ddr_data_length = r_len;
    assign o_chn_grant       = r_grant;
    assign o_req_lose        = r_lose;
    assign o_timeout         = r_tmo;

endmodule

// File: tb/tb_ddr3_vpi_wr_arbiter.sv
// Directed bench for ddr3_vpi_wr_arbiter: expected bursts are queued when requests are issued
// and popped when o_ddr_req appears; the watchdog is shortened to 16 cycles.
module tb_ddr3_vpi_wr_arbiter;
    typedef struct packed {
        logic [3:0]  grant;
        logic [11:0] len;
        logic [26:0] addr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        soft_rst;
    logic [3:0]  chn_req;
    logic [3:0]  chn_vs;
    logic [47:0] chn_len;
    logic        arb_mode;
    logic        ddr_ack;
    logic        ddr_wr_done;
    logic        ddr_req;
    logic [26:0] ddr_addr;
    logic [11:0] ddr_len;
    logic [3:0]  chn_grant;
    logic [7:0]  chn_frame;
    logic [3:0]  req_lose;
    logic        timeout;

    logic [11:0] lens    [4];
    logic [1:0]  m_frame [4];
    logic [22:0] m_ofs   [4];
    exp_t        sb[$];
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;
    assign chn_len = {lens[3], lens[2], lens[1], lens[0]};

    ddr3_vpi_wr_arbiter #(
        .CHN_BITS(2), .FRM_BITS(2), .ADDR_WIDTH(27), .LEN_WIDTH(12), .TIMEOUT_CYC(16)
    ) dut (
        .i_ddr_clk(clk), .i_rst_n(rst_n), .i_soft_rst(soft_rst),
        .i_chn_req(chn_req), .i_chn_vs(chn_vs), .i_chn_len(chn_len),
        .i_arb_mode(arb_mode), .i_ddr_ack(ddr_ack), .i_ddr_wr_done(ddr_wr_done),
        .o_ddr_req(ddr_req), .o_ddr_start_addr(ddr_addr), .o_ddr_data_length(ddr_len),
        .o_chn_grant(chn_grant), .o_chn_frame(chn_frame), .o_req_lose(req_lose),
        .o_timeout(timeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input int k);
        exp_t e;
        e.addr  = {2'(k), m_frame[k], m_ofs[k]};
        e.len   = lens[k];
        e.grant = 4'(1 << k);
        return e;
    endfunction

    task automatic push(input int k, input bit adv);
        sb.push_back(mk(k));
        if (adv) m_ofs[k] = m_ofs[k] + 23'(lens[k]);
    endtask

    task automatic pulse_req(input logic [3:0] m);
        chn_req = m;
        tick();
        chn_req = '0;
    endtask

    task automatic pulse_vs(input logic [3:0] m);
        chn_vs = m;
        tick();
        chn_vs = '0;
        for (int k = 0; k < 4; k++) begin
            if (m[k]) begin
                m_frame[k] = m_frame[k] + 2'd1;
                m_ofs[k]   = '0;
            end
        end
    endtask

    task automatic wait_req(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (ddr_req) break;
            tick();
        end
        chk(tag, ddr_req, 1'b1);
    endtask

    task automatic pop_chk();
        exp_t e;
        chk("sb_nonempty", sb.size() > 0, 1'b1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("addr", ddr_addr, e.addr);
            chk("len", ddr_len, e.len);
            chk("grant", chn_grant, e.grant);
        end
    endtask

    // Serves one burst; mid_req/mid_vs are pulsed while the burst sits in WAIT_DONE.
    task automatic serve(input logic [3:0] mid_req, input logic [3:0] mid_vs);
        wait_req("req_seen");
        pop_chk();
        ddr_ack = 1'b1;
        tick();
        ddr_ack = 1'b0;
        chk("req_drop", ddr_req, 1'b0);
        chn_req = mid_req;
        chn_vs  = mid_vs;
        tick();
        chn_req = '0;
        chn_vs  = '0;
        ddr_wr_done = 1'b1;
        tick();
        ddr_wr_done = 1'b0;
        chk("grant_clr", chn_grant, 4'h0);
    endtask

    initial begin
        rst_n = 1'b0; soft_rst = 1'b0; chn_req = '0; chn_vs = '0;
        arb_mode = 1'b0; ddr_ack = 1'b0; ddr_wr_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            lens[k] = 12'(16 * (k + 1));
            m_frame[k] = '0;
            m_ofs[k] = '0;
        end
        #12;
        chk("rst_req", ddr_req, 1'b0);
        chk("rst_grant", chn_grant, 4'h0);
        chk("rst_frame", chn_frame, 8'h00);
        chk("rst_addr", ddr_addr, 27'h0);
        chk("rst_tmo", timeout, 1'b0);
        chk("rst_lose", req_lose, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Round-robin, all four at once: order 0,1,2,3 and 3-edge request latency.
        for (int k = 0; k < 4; k++) push(k, 1'b1);
        pulse_req(4'hF);
        tick();
        tick();
        chk("lat_edge2", ddr_req, 1'b0);
        tick();
        chk("lat_edge3", ddr_req, 1'b1);
        for (int k = 0; k < 4; k++) serve(4'h0, 4'h0);

        // Double request on channel 1 before service: one lose pulse, one burst.
        push(1, 1'b1);
        chn_req = 4'b0010;
        tick();
        tick();
        chn_req = 4'b0000;
        chk("lose_pulse", req_lose, 4'b0010);
        tick();
        chk("lose_clear", req_lose, 4'b0000);
        serve(4'h0, 4'h0);
        repeat (6) tick();
        chk("no_second_burst", ddr_req, 1'b0);

        // Fixed priority: channel 0 overtakes channel 2's repeats; ch2 offsets step by 0x100.
        arb_mode = 1'b1;
        lens[2] = 12'd256;
        lens[0] = 12'd8;
        pulse_vs(4'b0100);
        chk("vs_idle_frame2", chn_frame[5:4], 2'd1);
        push(2, 1'b1);
        push(0, 1'b1);
        push(2, 1'b1);
        push(2, 1'b1);
        pulse_req(4'b0100);
        serve(4'b0101, 4'h0);
        serve(4'h0, 4'h0);
        serve(4'b0100, 4'h0);
        serve(4'h0, 4'h0);

        // vs on channel 3 while it is in WAIT_DONE is applied at wr_done.
        arb_mode = 1'b0;
        push(3, 1'b1);
        pulse_req(4'b1000);
        serve(4'h0, 4'b1000);
        m_frame[3] = m_frame[3] + 2'd1;
        m_ofs[3] = '0;
        chk("defer_frame3", chn_frame[7:6], 2'd1);
        push(3, 1'b1);
        pulse_req(4'b1000);
        serve(4'h0, 4'h0);

        // Watchdog: ch1 never acked, offset kept, ch2 granted next.
        push(1, 1'b0);
        push(2, 1'b1);
        pulse_req(4'b0110);
        wait_req("tmo_req_seen");
        pop_chk();
        repeat (14) tick();
        chk("tmo_early", timeout, 1'b0);
        tick();
        chk("tmo_pulse", timeout, 1'b1);
        chk("tmo_req_drop", ddr_req, 1'b0);
        chk("tmo_grant_clr", chn_grant, 4'h0);
        tick();
        chk("tmo_pulse_end", timeout, 1'b0);
        serve(4'h0, 4'h0);
        push(1, 1'b1);
        pulse_req(4'b0010);
        serve(4'h0, 4'h0);

        // Drive channel 0 offset to 2**23-16, then a 32-word burst wraps it to 16.
        pulse_vs(4'b0001);
        lens[0] = 12'd4095;
        for (int n = 0; n < 2048; n++) begin
            push(0, 1'b1);
            pulse_req(4'b0001);
            serve(4'h0, 4'h0);
        end
        lens[0] = 12'd2032;
        push(0, 1'b1);
        pulse_req(4'b0001);
        serve(4'h0, 4'h0);
        chk("wrap_pre_ofs", m_ofs[0], 23'h7FFFF0);
        lens[0] = 12'd32;
        push(0, 1'b1);
        pulse_req(4'b0001);
        serve(4'h0, 4'h0);
        push(0, 1'b0);
        pulse_req(4'b0001);
        wait_req("wrap_req_seen");
        pop_chk();
        chk("wrap_ofs16", ddr_addr[22:0], 23'd16);

        // Soft reset while in REQ.
        soft_rst = 1'b1;
        tick();
        soft_rst = 1'b0;
        chk("srst_req", ddr_req, 1'b0);
        chk("srst_grant", chn_grant, 4'h0);
        chk("srst_frame", chn_frame, 8'h00);
        for (int k = 0; k < 4; k++) begin
            m_frame[k] = '0;
            m_ofs[k] = '0;
        end
        push(0, 1'b1);
        push(3, 1'b1);
        pulse_req(4'b1001);
        serve(4'h0, 4'h0);
        serve(4'h0, 4'h0);
        chk("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
